// File: rtl/cipher_word_loader.sv
// Purpose: assembles UART RX bytes into a length-prefixed stream of cipher words and feeds them to the FME.
// Latency: last payload byte accepted -> fme_start after 2 cycles when the FIFO is empty and the FME is idle.
// Backpressure: the byte completing a payload word is held off (no clear_rx_flag) while the word FIFO is full.
module cipher_word_loader #(
    parameter int WORD_BYTES = 4,
    parameter int LEN_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    ready_in,
    input  logic [7:0]              data_in,
    output logic                    clear_rx_flag,
    input  logic                    fme_busy,
    output logic                    fme_start,
    output logic [8*WORD_BYTES-1:0] fme_data_in,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        msg_len
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [BC_W-1:0]   r_byte_cnt;
    logic [WORD_W-1:0] r_asm;
    logic              r_word_vld;
    logic [LEN_W-1:0]  r_msg_len;
    logic [LEN_W-1:0]  r_rx_cnt;
    logic [LEN_W-1:0]  r_tx_cnt;

    logic [WORD_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fifo_cnt;

    logic              r_fme_start;
    logic [WORD_W-1:0] r_fme_data;
    logic              r_done;

    logic              w_start_ok;
    logic              w_last_byte;
    logic [LEN_W-1:0]  w_rx_nxt;
    logic              w_push;
    logic              w_push_last;
    logic              w_fifo_full;
    logic              w_accept;
    logic              w_pop;
    logic              w_bypass;
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic [WORD_W-1:0] w_head;
    logic              w_done_hdr;
    logic              w_done_drain;
    logic [WORD_W-1:0] w_asm_nxt;

    // Byte insertion order into the assembly register.
    generate
        if (WORD_BYTES == 1) begin : g_one
            assign w_asm_nxt = data_in;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign w_asm_nxt = {r_asm[WORD_W-9:0], data_in};
        end else begin : g_lsb
            assign w_asm_nxt = {data_in, r_asm[WORD_W-1:8]};
        end
    endgenerate

    // Handshake, stall, dispatch and completion decisions for the current cycle.
    always_comb begin
        w_start_ok  = (r_state == S_IDLE) && start && !abort;
        w_last_byte = (r_byte_cnt == BC_W'(WORD_BYTES - 1));
        w_rx_nxt    = r_rx_cnt + LEN_W'(1);
        // A completed word sits in r_asm for exactly one cycle and is pushed then.
        w_push      = (r_state == S_PAYLOAD) && r_word_vld;
        w_push_last = w_push && (w_rx_nxt == r_msg_len);
        // A word already waiting to be pushed counts against the free space.
        w_fifo_full = (r_fifo_cnt + CNT_W'(w_push)) >= CNT_W'(FIFO_DEPTH);

        w_accept = 1'b0;
        if (!abort && ready_in) begin
            case (r_state)
                // Length unknown until the header word is latched, so hold bytes off that cycle.
                S_HEADER:  w_accept = !r_word_vld;
                // Never take bytes beyond the final word, never overrun the FIFO.
                S_PAYLOAD: w_accept = !w_push_last && !(w_last_byte && w_fifo_full);
                default:   w_accept = 1'b0;
            endcase
        end
        clear_rx_flag = w_start_ok || w_accept;

        // Guard on the previous start pulse covers the FME's one-cycle busy rise.
        w_pop    = ((r_state == S_PAYLOAD) || (r_state == S_DRAIN)) && !abort &&
                   !fme_busy && !r_fme_start && ((r_fifo_cnt != '0) || w_push);
        // Empty FIFO: hand the freshly assembled word straight to the FME.
        w_bypass  = w_pop && (r_fifo_cnt == '0);
        w_fifo_wr = w_push && !w_bypass;
        w_fifo_rd = w_pop && !w_bypass;
        w_head    = w_bypass ? r_asm : r_fifo[r_rd_ptr];

        w_done_hdr   = (r_state == S_HEADER) && r_word_vld && (r_asm[LEN_W-1:0] == '0);
        w_done_drain = (r_state == S_DRAIN) && (r_tx_cnt == r_msg_len) &&
                       (r_fifo_cnt == '0) && !fme_busy && !r_fme_start;
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                if (r_word_vld) w_state_nxt = w_done_hdr ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (w_push_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done_drain) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Byte assembly: shift accepted bytes in, flag the cycle after a word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_word_vld <= 1'b0;
        end else if (abort || w_start_ok) begin
            r_byte_cnt <= '0;
            r_word_vld <= 1'b0;
            if (w_start_ok) r_asm <= '0;
        end else begin
            r_word_vld <= w_accept && w_last_byte;
            if (w_accept) begin
                r_asm      <= w_asm_nxt;
                r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BC_W'(1);
            end
        end
    end

    // Message length and received/dispatched word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_len <= '0;
            r_rx_cnt  <= '0;
            r_tx_cnt  <= '0;
        end else if (abort) begin
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
        end else if (w_start_ok) begin
            r_msg_len <= '0;
            r_rx_cnt  <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if ((r_state == S_HEADER) && r_word_vld) r_msg_len <= r_asm[LEN_W-1:0];
            if (w_push) r_rx_cnt <= w_rx_nxt;
            if (w_pop)  r_tx_cnt <= r_tx_cnt + LEN_W'(1);
        end
    end

    // FIFO pointers and occupancy; bypassed words never touch them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (abort || w_start_ok) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_fifo_wr && !abort) r_fifo[r_wr_ptr] <= r_asm;
    end

    // FME launch pulse, held word, and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fme_start <= 1'b0;
            r_fme_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_fme_start <= w_pop;
            if (w_pop) r_fme_data <= w_head;
            r_done <= !abort && (w_done_hdr || w_done_drain);
        end
    end

    assign fme_start   = r_fme_start;
    assign fme_data_in = r_fme_data;
    assign done        = r_done;
    assign msg_len     = r_msg_len;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cipher_word_loader.sv
// Purpose: directed bench for cipher_word_loader, MSB-first and LSB-first instances side by side.
// Latency: FME model raises busy the cycle after fme_start and holds it for busy_len cycles.
// Backpressure: RX model holds ready_in until clear_rx_flag, stuck busy forces FIFO-full stalls.
module tb_cipher_word_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, abort;
    logic        ready_a, ready_b;
    logic [7:0]  data_in;
    logic        stuck, model_busy;
    logic        fme_busy;
    logic        clr_a, fst_a, busy_a, done_a;
    logic        clr_b, fst_b, busy_b, done_b;
    logic [31:0] fdat_a, mlen_a, fdat_b, mlen_b;

    assign fme_busy = stuck | model_busy;

    cipher_word_loader #(.WORD_BYTES(4), .LEN_W(32), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .ready_in(ready_a),
        .data_in(data_in), .clear_rx_flag(clr_a), .fme_busy(fme_busy), .fme_start(fst_a),
        .fme_data_in(fdat_a), .busy(busy_a), .done(done_a), .msg_len(mlen_a));

    cipher_word_loader #(.WORD_BYTES(4), .LEN_W(32), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .ready_in(ready_b),
        .data_in(data_in), .clear_rx_flag(clr_b), .fme_busy(fme_busy), .fme_start(fst_b),
        .fme_data_in(fdat_b), .busy(busy_b), .done(done_b), .msg_len(mlen_b));

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0, n_total = 0;
    int          n_done_a = 0, n_done_b = 0;
    int          done_cyc = 0, fall_cyc = 0, last_acc_cyc = 0;
    int          busy_len = 3;
    bit          sel_b = 1'b0;
    logic [31:0] st_log[$];
    int          st_cyc[$];

    typedef struct {
        logic [31:0] stream;
        logic [31:0] exp_msb;
        logic [31:0] exp_lsb;
    } vec_t;
    vec_t vt[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a === 1'b1) begin n_done_a++; done_cyc = cyc; end
        if (done_b === 1'b1) n_done_b++;
    end

    // FME model: logs each launch, busy rises next cycle for busy_len cycles.
    always begin
        @(negedge clk);
        if (fst_a === 1'b1 || fst_b === 1'b1) begin
            st_log.push_back(fst_b ? fdat_b : fdat_a);
            st_cyc.push_back(cyc);
            @(posedge clk); #1;
            model_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1;
            model_busy = 1'b0;
            fall_cyc = cyc;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        data_in = b;
        if (sel_b) ready_b = 1'b1; else ready_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel_b ? clr_b : clr_a) === 1'b1) begin
                last_acc_cyc = cyc;
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        ready_a = 1'b0;
        ready_b = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL byte_accept_timeout: got no clear_rx_flag, required one for byte %0h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] s, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(s[31-8*i -: 8]);
    endtask

    task automatic start_msg();
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((sel_b ? busy_b : busy_a) === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, lim);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int acc1;
        int clr_seen;
        rst = 1'b1; start_a = 0; start_b = 0; abort = 0; ready_a = 0; ready_b = 0;
        data_in = 8'h00; stuck = 0; model_busy = 0;

        vt[0] = '{32'hEFBEADDE, 32'hEFBEADDE, 32'hDEADBEEF};
        vt[1] = '{32'h01234567, 32'h01234567, 32'h67452301};
        vt[2] = '{32'h80000001, 32'h80000001, 32'h01000080};
        vt[3] = '{32'hA5C30F96, 32'hA5C30F96, 32'h960FC3A5};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_fme_start", fst_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_clear", clr_a, 1'b0);
        check("rst_fme_data", fdat_a, 32'h0);
        check("rst_msg_len", mlen_a, 32'h0);
        check("rst_busy_b", busy_b, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Table: one-word messages through both byte orders
        busy_len = 3;
        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < 2; s++) begin
                sel_b = (s == 1);
                st_log.delete(); st_cyc.delete();
                base = sel_b ? n_done_b : n_done_a;
                start_msg();
                send_word(sel_b ? 32'h01000000 : 32'h00000001, 4);
                send_word(vt[v].stream, 4);
                wait_idle(100, $sformatf("vec%0d_%0d_idle", v, s));
                check($sformatf("vec%0d_%0d_nstart", v, s), 64'(st_log.size()), 64'd1);
                if (st_log.size() > 0)
                    check($sformatf("vec%0d_%0d_data", v, s), st_log[0],
                          sel_b ? vt[v].exp_lsb : vt[v].exp_msb);
                check($sformatf("vec%0d_%0d_msg_len", v, s), sel_b ? mlen_b : mlen_a, 32'd1);
                check($sformatf("vec%0d_%0d_done", v, s),
                      64'((sel_b ? n_done_b : n_done_a) - base), 64'd1);
            end
        end
        sel_b = 1'b0;

        // Two words, FME busy 10 cycles each
        busy_len = 10;
        st_log.delete(); st_cyc.delete();
        base = n_done_a;
        start_msg();
        send_word(32'h00000002, 4);
        send_word(32'hDEADBEEF, 4);
        acc1 = last_acc_cyc;
        send_word(32'h01234567, 4);
        wait_idle(200, "two_idle");
        check("two_nstart", 64'(st_log.size()), 64'd2);
        if (st_log.size() == 2) begin
            check("two_data0", st_log[0], 32'hDEADBEEF);
            check("two_data1", st_log[1], 32'h01234567);
            check("two_latency", 64'(st_cyc[0] - acc1), 64'd2);
        end
        check("two_msg_len", mlen_a, 32'd2);
        check("two_done", 64'(n_done_a - base), 64'd1);
        check("two_done_after_fall", 64'(done_cyc - fall_cyc), 64'd1);

        // FME stuck busy: FIFO fills, completing byte stalls, then drains in order
        stuck = 1'b1;
        st_log.delete(); st_cyc.delete();
        base = n_done_a;
        start_msg();
        send_word(32'h00000006, 4);
        for (int w = 0; w < 4; w++) send_word(32'h10203040 + 32'(w), 4);
        send_word(32'h50607080, 3);
        data_in = 8'h80;
        ready_a = 1'b1;
        clr_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (clr_a === 1'b1) clr_seen++;
        end
        check("stall_no_clear", 64'(clr_seen), 64'd0);
        check("stall_no_start", 64'(st_log.size()), 64'd0);
        @(posedge clk); #1;
        stuck = 1'b0;
        send_byte(8'h80);
        send_word(32'h90A0B0C0, 4);
        wait_idle(400, "stall_idle");
        check("stall_nstart", 64'(st_log.size()), 64'd6);
        if (st_log.size() == 6) begin
            for (int w = 0; w < 4; w++)
                check($sformatf("stall_data%0d", w), st_log[w], 32'h10203040 + 32'(w));
            check("stall_data4", st_log[4], 32'h50607080);
            check("stall_data5", st_log[5], 32'h90A0B0C0);
        end
        check("stall_done", 64'(n_done_a - base), 64'd1);

        // Zero-length header with a stale byte pending at start
        st_log.delete(); st_cyc.delete();
        base = n_done_a;
        data_in = 8'h55;
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        check("zero_stale_clear", clr_a, 1'b1);
        @(posedge clk); #1;
        start_a = 1'b0;
        ready_a = 1'b0;
        send_word(32'h00000000, 4);
        wait_idle(50, "zero_idle");
        check("zero_done", 64'(n_done_a - base), 64'd1);
        check("zero_nstart", 64'(st_log.size()), 64'd0);
        check("zero_msg_len", mlen_a, 32'd0);

        // Abort mid-payload after two dispatches
        busy_len = 20;
        st_log.delete(); st_cyc.delete();
        base = n_done_a;
        start_msg();
        send_word(32'h00000005, 4);
        send_word(32'h11111111, 4);
        send_word(32'h22222222, 4);
        for (int i = 0; i < 200 && st_log.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        check("abort_two_sent", 64'(st_log.size()), 64'd2);
        send_word(32'h33333333, 4);
        send_word(32'h44444444, 2);
        abort = 1'b1;
        data_in = 8'h44;
        ready_a = 1'b1;
        @(negedge clk);
        check("abort_blocks_accept", clr_a, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        ready_a = 1'b0;
        @(negedge clk);
        check("abort_idle", busy_a, 1'b0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done_a - base), 64'd0);
        check("abort_no_more_start", 64'(st_log.size()), 64'd2);
        @(posedge clk); #1;
        st_log.delete(); st_cyc.delete();
        base = n_done_a;
        start_msg();
        send_word(32'h00000001, 4);
        send_word(32'hCAFEF00D, 4);
        wait_idle(200, "after_abort_idle");
        check("after_abort_nstart", 64'(st_log.size()), 64'd1);
        if (st_log.size() == 1) check("after_abort_data", st_log[0], 32'hCAFEF00D);
        check("after_abort_done", 64'(n_done_a - base), 64'd1);
        check("after_abort_msg_len", mlen_a, 32'd1);

        // Asynchronous reset while an fme_start pulse is high
        busy_len = 10;
        repeat (25) @(posedge clk); #1;
        start_msg();
        send_word(32'h00000002, 4);
        send_word(32'h76543210, 4);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (fst_a === 1'b1) begin seen = 1'b1; break; end
            end
            check("rstmid_start_seen", seen, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        check("rstmid_fme_start", fst_a, 1'b0);
        check("rstmid_busy", busy_a, 1'b0);
        check("rstmid_fme_data", fdat_a, 32'h0);
        check("rstmid_msg_len", mlen_a, 32'h0);
        check("rstmid_done", done_a, 1'b0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
